// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle control FSM for the RV32I datapath.
// Drives datapath write enables and mux selects, handshakes with instruction
// and data memory (req held until ready) and stops in ERR when a request
// waits too long. Define MC_CTRL_TRAP_EN to route illegal opcodes through a
// one-cycle TRAP state; otherwise they retire as NOPs.
module mc_ctrl_unit #(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                ZF,
  input  logic                SF,
  input  logic                CF,
  input  logic                OF,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                PC_Write,
  output logic                PC0_Write,
  output logic                IR_Write,
  output logic                Reg_Write,
  output logic                Mem_Write,
  output logic                SE_s,
  output logic [1:0]          Size_s,
  output logic [1:0]          PC_s,
  output logic                rs2_imm_s,
  output logic [2:0]          w_data_s,
  output logic                illegal,
  output logic                mem_err,
  output logic [3:0]          state
);

  localparam int unsigned CntW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StEx   = 4'd2,
    StMem  = 4'd3,
    StWb   = 4'd4,
    StBr   = 4'd5,
`ifdef MC_CTRL_TRAP_EN
    StTrap = 4'd6,
`endif
    StErr  = 4'd7
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] alu_fn;
  logic                br_taken;
  logic                timeout;
  logic                req_pend;
  logic                ready_now;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  assign is_r     = (opcode == OpR);
  assign is_i     = (opcode == OpI);
  assign is_ld    = (opcode == OpLoad);
  assign is_st    = (opcode == OpStore);
  assign is_br    = (opcode == OpBr);
  assign is_jal   = (opcode == OpJal);
  assign is_jalr  = (opcode == OpJalr);
  assign is_lui   = (opcode == OpLui);
  assign is_auipc = (opcode == OpAuipc);

  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Wait-counter bookkeeping: a request is pending in IF and MEM only.
  assign req_pend  = (state_q == StIf) || (state_q == StMem);
  assign ready_now = (state_q == StIf) ? imem_ready : dmem_ready;
  assign timeout   = (MEM_TIMEOUT != 0) && (cnt_q == CntMax);

  // ALU function: only R-type honours func7[5] on func3=0 (ADDI has no SUBI).
  always_comb begin
    alu_fn = ALU_OP_W'(0);
    if (is_r || is_i) begin
      unique case (func3)
        3'd0: alu_fn = (is_r && func7[5]) ? ALU_OP_W'(1) : ALU_OP_W'(0);
        3'd1: alu_fn = ALU_OP_W'(2);
        3'd2: alu_fn = ALU_OP_W'(3);
        3'd3: alu_fn = ALU_OP_W'(4);
        3'd4: alu_fn = ALU_OP_W'(5);
        3'd5: alu_fn = func7[5] ? ALU_OP_W'(7) : ALU_OP_W'(6);
        3'd6: alu_fn = ALU_OP_W'(8);
        3'd7: alu_fn = ALU_OP_W'(9);
        default: alu_fn = ALU_OP_W'(0);
      endcase
    end else if (is_br) begin
      alu_fn = ALU_OP_W'(1);
    end
  end

  // Branch condition from the flags latched at the end of EX.
  always_comb begin
    br_taken = 1'b0;
    unique case (func3)
      3'b000:  br_taken = ZF;
      3'b001:  br_taken = !ZF;
      3'b100:  br_taken = SF ^ OF;
      3'b101:  br_taken = !(SF ^ OF);
      3'b110:  br_taken = CF;
      3'b111:  br_taken = !CF;
      default: br_taken = 1'b0;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter counts unanswered request cycles, saturating at the limit.
  always_comb begin
    cnt_d = '0;
    if (req_pend && !ready_now) begin
      cnt_d = (cnt_q != CntMax) ? cnt_q + 1'b1 : cnt_q;
    end
  end

  // Next-state logic; ready is tested before timeout so ready wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf: begin
        if (imem_ready)   state_d = StId;
        else if (timeout) state_d = StErr;
      end
      StId: begin
        if (is_lui || is_auipc) begin
          state_d = StWb;
        end else if (is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr) begin
          state_d = StEx;
        end else begin
`ifdef MC_CTRL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StIf;
`endif
        end
      end
      StEx: begin
        if (is_jal)              state_d = StIf;
        else if (is_ld || is_st) state_d = StMem;
        else if (is_br)          state_d = StBr;
        else                     state_d = StWb;
      end
      StMem: begin
        if (dmem_ready)   state_d = is_ld ? StWb : StIf;
        else if (timeout) state_d = StErr;
      end
      StWb:    state_d = StIf;
      StBr:    state_d = StIf;
`ifdef MC_CTRL_TRAP_EN
      StTrap:  state_d = StIf;
`endif
      StErr:   state_d = StErr;
      default: state_d = StIf;
    endcase
  end

  // Outputs from the registered state plus current inputs; all zero in reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ALU_OP    = '0;
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_Write = 1'b0;
    SE_s      = 1'b0;
    Size_s    = 2'd0;
    PC_s      = 2'd0;
    rs2_imm_s = 1'b0;
    w_data_s  = 3'd0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    state     = rst_ ? 4'd0 : state_q;
    if (!rst_) begin
      case (state_q)
        StIf: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            IR_Write  = 1'b1;
            PC0_Write = 1'b1;
            PC_Write  = 1'b1;
          end
        end
        StEx: begin
          ALU_OP    = alu_fn;
          rs2_imm_s = is_i || is_ld || is_st || is_jalr;
          if (is_jal) begin
            Reg_Write = 1'b1;
            w_data_s  = 3'd3;
            PC_Write  = 1'b1;
            PC_s      = 2'd1;
          end
        end
        StMem: begin
          dmem_req  = 1'b1;
          Mem_Write = is_st;
          Size_s    = func3[1:0];
          SE_s      = ~func3[2];
        end
        StWb: begin
          Reg_Write = 1'b1;
          if (is_lui)        w_data_s = 3'd1;
          else if (is_auipc) w_data_s = 3'd4;
          else if (is_ld)    w_data_s = 3'd2;
          else if (is_jalr)  w_data_s = 3'd3;
          if (is_jalr) begin
            PC_Write = 1'b1;
            PC_s     = 2'd2;
          end
        end
        StBr: begin
          if (br_taken) begin
            PC_Write = 1'b1;
            PC_s     = 2'd1;
          end
        end
`ifdef MC_CTRL_TRAP_EN
        StTrap: begin
          PC_Write = 1'b1;
          PC_s     = 2'd3;
          illegal  = 1'b1;
        end
`endif
        StErr:   mem_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-cycle expected output vectors are
// queued when stimulus is applied and checked at the falling edge.
module tb_mc_ctrl_unit;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic [3:0] alu_op;
    logic       pc_write;
    logic       pc0_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       se_s;
    logic [1:0] size_s;
    logic [1:0] pc_s;
    logic       rs2_imm_s;
    logic [2:0] w_data_s;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       ZF, SF, CF, OF;
  logic       imem_ready, dmem_ready;
  logic       imem_req, dmem_req;
  logic [3:0] ALU_OP;
  logic       PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_Write, SE_s;
  logic [1:0] Size_s, PC_s;
  logic       rs2_imm_s;
  logic [2:0] w_data_s;
  logic       illegal, mem_err;
  logic [3:0] state;

  outs_t obs;
  outs_t e;
  sb_t   sb_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  mc_ctrl_unit #(
    .ALU_OP_W   (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .opcode    (opcode),
    .func3     (func3),
    .func7     (func7),
    .ZF        (ZF),
    .SF        (SF),
    .CF        (CF),
    .OF        (OF),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .ALU_OP    (ALU_OP),
    .PC_Write  (PC_Write),
    .PC0_Write (PC0_Write),
    .IR_Write  (IR_Write),
    .Reg_Write (Reg_Write),
    .Mem_Write (Mem_Write),
    .SE_s      (SE_s),
    .Size_s    (Size_s),
    .PC_s      (PC_s),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .illegal   (illegal),
    .mem_err   (mem_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, ALU_OP, PC_Write, PC0_Write, IR_Write, Reg_Write,
                Mem_Write, SE_s, Size_s, PC_s, rs2_imm_s, w_data_s, illegal, mem_err, state};

  // Queue the current expectation, check it mid-cycle, then move past the next edge.
  task automatic step(input string tag);
    sb_t item;
    sb_q.push_back('{tag, e});
    @(negedge clk);
    item = sb_q.pop_front();
    n_cmp++;
    assert (obs === item.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic exp_state(input logic [3:0] s);
    e = '0;
    e.state = s;
  endtask

  task automatic exp_fetch();
    exp_state(4'd0);
    e.imem_req  = 1'b1;
    e.ir_write  = 1'b1;
    e.pc0_write = 1'b1;
    e.pc_write  = 1'b1;
  endtask

  initial begin
    rst_       = 1'b1;
    opcode     = 7'b0110011;
    func3      = 3'd0;
    func7      = 7'h20;
    {ZF, SF, CF, OF} = 4'b0000;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;

    // Reset held three cycles: every output low.
    for (int i = 0; i < 3; i++) begin
      exp_state(4'd0);
      step("reset_outputs");
    end
    rst_ = 1'b0;

    // R-type SUB: IF, ID, EX, WB.
    exp_fetch();                                  step("sub_if");
    exp_state(4'd1);                              step("sub_id");
    exp_state(4'd2); e.alu_op = 4'd1;             step("sub_ex");
    exp_state(4'd4); e.reg_write = 1'b1;          step("sub_wb");

    // LW with dmem_ready delayed two cycles.
    opcode = 7'b0000011; func3 = 3'b010; func7 = 7'h00;
    exp_fetch();                                  step("lw_if");
    exp_state(4'd1);                              step("lw_id");
    exp_state(4'd2); e.rs2_imm_s = 1'b1;          step("lw_ex");
    for (int i = 0; i < 3; i++) begin
      dmem_ready = (i == 2);
      exp_state(4'd3); e.dmem_req = 1'b1; e.size_s = 2'd2; e.se_s = 1'b1;
      step("lw_mem");
    end
    dmem_ready = 1'b0;
    exp_state(4'd4); e.reg_write = 1'b1; e.w_data_s = 3'd2; step("lw_wb");

    // BLTU taken (CF=1) then not taken (CF=0).
    opcode = 7'b1100011; func3 = 3'b110;
    for (int k = 0; k < 2; k++) begin
      CF = (k == 0);
      exp_fetch();                                step("bltu_if");
      exp_state(4'd1);                            step("bltu_id");
      exp_state(4'd2); e.alu_op = 4'd1;           step("bltu_ex");
      exp_state(4'd5);
      if (k == 0) begin
        e.pc_write = 1'b1; e.pc_s = 2'd1;
      end
      step(k == 0 ? "bltu_br_taken" : "bltu_br_not_taken");
    end
    CF = 1'b0;

    // JAL completes in EX.
    opcode = 7'b1101111; func3 = 3'd0;
    exp_fetch();                                  step("jal_if");
    exp_state(4'd1);                              step("jal_id");
    exp_state(4'd2); e.reg_write = 1'b1; e.w_data_s = 3'd3; e.pc_write = 1'b1; e.pc_s = 2'd1;
    step("jal_ex");

    // JALR: WB writes PC+4 and redirects to F.
    opcode = 7'b1100111;
    exp_fetch();                                  step("jalr_if");
    exp_state(4'd1);                              step("jalr_id");
    exp_state(4'd2); e.rs2_imm_s = 1'b1;          step("jalr_ex");
    exp_state(4'd4); e.reg_write = 1'b1; e.w_data_s = 3'd3; e.pc_write = 1'b1; e.pc_s = 2'd2;
    step("jalr_wb");

    // SW, reset asserted while waiting in MEM.
    opcode = 7'b0100011; func3 = 3'b010;
    exp_fetch();                                  step("sw_if");
    exp_state(4'd1);                              step("sw_id");
    exp_state(4'd2); e.rs2_imm_s = 1'b1;          step("sw_ex");
    exp_state(4'd3); e.dmem_req = 1'b1; e.mem_write = 1'b1; e.size_s = 2'd2; e.se_s = 1'b1;
    step("sw_mem_wait");
    rst_ = 1'b1;
    exp_state(4'd0);                              step("sw_mem_reset");
    rst_ = 1'b0;

    // Timeout: imem_ready held low; counter 0..4 in IF, then ERR.
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_state(4'd0); e.imem_req = 1'b1;         step("to_if_wait");
    end
    exp_state(4'd7); e.mem_err = 1'b1;            step("to_err");
    imem_ready = 1'b1;
    exp_state(4'd7); e.mem_err = 1'b1;            step("to_err_sticky");
    rst_ = 1'b1;
    exp_state(4'd0);                              step("to_err_reset");
    rst_ = 1'b0;

    // Ready on the cycle the counter reaches the limit: ready wins.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_state(4'd0); e.imem_req = 1'b1;         step("tie_if_wait");
    end
    imem_ready = 1'b1;
    opcode = 7'b1111111;
    exp_fetch();                                  step("tie_fetch");

    // Illegal opcode.
    exp_state(4'd1);                              step("ill_id");
`ifdef MC_CTRL_TRAP_EN
    exp_state(4'd6); e.pc_write = 1'b1; e.pc_s = 2'd3; e.illegal = 1'b1;
    step("ill_trap");
`endif
    // LUI right after: IF, ID, WB.
    opcode = 7'b0110111;
    exp_fetch();                                  step("ill_next_if");
    exp_state(4'd1);                              step("lui_id");
    exp_state(4'd4); e.reg_write = 1'b1; e.w_data_s = 3'd1; step("lui_wb");

    // AUIPC.
    opcode = 7'b0010111;
    exp_fetch();                                  step("auipc_if");
    exp_state(4'd1);                              step("auipc_id");
    exp_state(4'd4); e.reg_write = 1'b1; e.w_data_s = 3'd4; step("auipc_wb");

    exp_state(4'd0); e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc0_write = 1'b1;
    e.pc_write = 1'b1;
    step("final_if");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
